bt656_sync_encoder: RTL

//  Transmit side of the 8-bit embedded-sync video link: converts parallel camera video (pixel bytes

---
 rtl/bt656_sync_encoder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/bt656_sync_encoder.sv
// bt656_sync_encoder: turns fv/lv-qualified parallel video into a byte stream
// with embedded FF 00 00 XY timing codes. Synthetic blanking lines are emitted
// while fv is low so the receiver keeps lock between frames.
module bt656_sync_encoder #(
    parameter int unsigned VB_LINE_LEN   = 1000,
    parameter int unsigned VB_ACTIVE_LEN = 800
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic [7:0] pix_data,
    input  logic       fv,
    input  logic       lv,
    output logic [7:0] data_out,
    output logic       active_out,
    output logic       sync_err
);

    localparam int unsigned TW    = $clog2(VB_LINE_LEN);
    localparam int unsigned H_SAV = VB_LINE_LEN - VB_ACTIVE_LEN - 4;

    localparam logic [TW-1:0] T_LAST    = TW'(VB_LINE_LEN - 1);
    localparam logic [TW-1:0] T_SAV     = TW'(H_SAV);
    localparam logic [TW-1:0] T_SAV_END = TW'(H_SAV + 4);
    localparam logic [TW-1:0] T_FOUR    = TW'(4);
    localparam logic [TW-1:0] T_THREE   = TW'(3);

    typedef enum logic [2:0] {
        ST_VBLANK,
        ST_HBLANK,
        ST_SAV,
        ST_ACTIVE,
        ST_EAV
    } state_t;

    // XY = {1,F,V,H,V^H,F^H,F^V,F^V^H} with F fixed at 0 (progressive only)
    function automatic logic [7:0] xy_code(input logic v, input logic h);
        logic f;
        f = 1'b0;
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

    function automatic logic [7:0] code_byte(input logic [1:0] idx, input logic [7:0] xy);
        case (idx)
            2'd0:    return 8'hFF;
            2'd1,
            2'd2:    return 8'h00;
            default: return xy;
        endcase
    endfunction

    function automatic logic [7:0] clamp(input logic [7:0] p);
        if (p == 8'h00)      return 8'h01;
        else if (p == 8'hFF) return 8'hFE;
        else                 return p;
    endfunction

    localparam logic [7:0] XY_SAV_ACT = xy_code(1'b0, 1'b0);
    localparam logic [7:0] XY_EAV_ACT = xy_code(1'b0, 1'b1);
    localparam logic [7:0] XY_SAV_BLK = xy_code(1'b1, 1'b0);
    localparam logic [7:0] XY_EAV_BLK = xy_code(1'b1, 1'b1);

    state_t          state_q,    state_d;
    logic [TW-1:0]   tmr_q,      tmr_d;
    logic [1:0]      cnt_q,      cnt_d;
    logic            fill_q,     fill_d;
    logic            supp_q,     supp_d;
    logic [3:0][7:0] dly_pix_q,  dly_pix_d;
    logic [3:0]      dly_lv_q,   dly_lv_d;
    logic [7:0]      data_out_q, data_out_d;
    logic            active_q,   active_d;
    logic            err_q,      err_d;

    logic            lv_rise;
    logic            vb_in_eav, vb_in_sav, vb_busy, vb_last, blank_mode;
    logic [TW-1:0]   sav_off;

    // Decode the synthetic-blanking timer and the input line start
    always_comb begin
        lv_rise   = fv & lv & ~dly_lv_q[0] & ~supp_q;
        sav_off   = tmr_q - T_SAV;
        vb_in_eav = (tmr_q < T_FOUR);
        vb_in_sav = (tmr_q >= T_SAV) && (tmr_q < T_SAV_END);
        vb_busy   = (vb_in_eav && (tmr_q != '0)) || (vb_in_sav && (tmr_q != T_SAV));
        vb_last   = (tmr_q == T_THREE) || (sav_off == T_THREE);
        // An idle VBLANK with fv high behaves exactly like HBLANK, so both share one path
        blank_mode = (state_q == ST_HBLANK) || ((state_q == ST_VBLANK) && fv && !vb_busy);
    end

    // Next-state, output byte and delay-line computation
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        cnt_d      = cnt_q;
        fill_d     = fill_q;
        supp_d     = supp_q & lv;
        data_out_d = data_out_q;
        active_d   = 1'b0;
        err_d      = lv_rise & ~blank_mode;
        dly_pix_d  = {dly_pix_q[2:0], pix_data};
        dly_lv_d   = {dly_lv_q[2:0], lv};

        if (blank_mode) begin
            if (lv_rise) begin
                data_out_d = 8'hFF;
                fill_d     = 1'b0;
                cnt_d      = 2'd1;
                state_d    = ST_SAV;
            end else begin
                data_out_d = fill_q ? 8'h10 : 8'h80;
                fill_d     = ~fill_q;
                state_d    = fv ? ST_HBLANK : ST_VBLANK;
                if (!fv) tmr_d = '0;
            end
        end else begin
            case (state_q)
                ST_VBLANK: begin
                    tmr_d = (tmr_q == T_LAST) ? '0 : tmr_q + TW'(1);
                    if (vb_in_eav) begin
                        data_out_d = code_byte(tmr_q[1:0], XY_EAV_BLK);
                        fill_d     = 1'b0;
                    end else if (vb_in_sav) begin
                        data_out_d = code_byte(sav_off[1:0], XY_SAV_BLK);
                        fill_d     = 1'b0;
                    end else begin
                        data_out_d = fill_q ? 8'h10 : 8'h80;
                        fill_d     = ~fill_q;
                    end
                    if (fv && vb_busy && vb_last) state_d = ST_HBLANK;
                end
                ST_SAV: begin
                    data_out_d = code_byte(cnt_q, XY_SAV_ACT);
                    fill_d     = 1'b0;
                    cnt_d      = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (dly_lv_q[3]) begin
                        data_out_d = clamp(dly_pix_q[3]);
                        active_d   = 1'b1;
                    end else begin
                        data_out_d = 8'hFF;
                        fill_d     = 1'b0;
                        cnt_d      = 2'd1;
                        state_d    = ST_EAV;
                    end
                end
                ST_EAV: begin
                    data_out_d = code_byte(cnt_q, XY_EAV_ACT);
                    fill_d     = 1'b0;
                    cnt_d      = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = fv ? ST_HBLANK : ST_VBLANK;
                        tmr_d   = '0;
                    end
                end
                default: state_d = ST_VBLANK;
            endcase
        end

        if (err_d) supp_d = 1'b1;
    end

    // State, delay line and registered outputs
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_VBLANK;
            tmr_q      <= '0;
            cnt_q      <= '0;
            fill_q     <= 1'b0;
            supp_q     <= 1'b0;
            dly_pix_q  <= '0;
            dly_lv_q   <= '0;
            data_out_q <= 8'h80;
            active_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            supp_q     <= supp_d;
            dly_pix_q  <= dly_pix_d;
            dly_lv_q   <= dly_lv_d;
            data_out_q <= data_out_d;
            active_q   <= active_d;
            err_q      <= err_d;
        end
    end

    assign data_out   = data_out_q;
    assign active_out = active_q;
    assign sync_err   = err_q;

endmodule
